// File: rtl/prog_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_counter_seq_ctrl
// Description : Interval sequencer driving an external prog_counter. It loads,
//               runs and re-arms the counter, and pulses tick/done/err.
//               Optional pause support is enabled with macro CNT_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_counter_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CNT_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_up,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             err,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] cnt_load_value,
    output logic [WIDTH-1:0] cnt_max_count,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_tc,
    input  logic             cnt_zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
`ifdef CNT_PAUSE_EN
        ,ST_PAUSE = 2'd3
`endif
    } state_t;

    localparam logic [REP_W-1:0] c_rep_one = REP_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_period;
    logic               r_up;
    logic [REP_W-1:0]   r_rem;
    logic [REP_W-1:0]   w_rem_nxt;
    logic               r_tick;
    logic               r_done;
    logic               r_err;
    logic               w_tick_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_latch;
    logic               w_end;

    // The live count is status-only for this sequencer.
    logic               w_unused_count;
    assign w_unused_count = ^cnt_count;

    assign w_end = (r_up & cnt_tc) | (~r_up & cnt_zero);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_latch     = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_period == '0) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_latch     = 1'b1;
                            w_rem_nxt   = cfg_repeat;
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_end) begin
                        w_tick_nxt = 1'b1;
                        if (r_rem == c_rep_one) begin
                            w_done_nxt  = 1'b1;
                            w_rem_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            // A remaining count of zero means run until stopped.
                            if (r_rem != '0) begin
                                w_rem_nxt = r_rem - c_rep_one;
                            end
                            w_state_nxt = ST_LOAD;
                        end
                    end
`ifdef CNT_PAUSE_EN
                    else if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
`endif
                end
`ifdef CNT_PAUSE_EN
                ST_PAUSE: begin
                    if (!pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_up     <= 1'b0;
            r_rem    <= '0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_period <= cfg_period;
                r_up     <= cfg_up;
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign tick           = r_tick;
    assign done           = r_done;
    assign err            = r_err;
    assign cnt_load       = (r_state == ST_LOAD);
    assign cnt_enable     = (r_state == ST_RUN);
    assign cnt_up_down    = r_up;
    assign cnt_max_count  = r_period;
    assign cnt_load_value = r_up ? '0 : r_period;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_counter_seq_ctrl
// Description : Random-stimulus bench with a timing-level reference model and
//               an emulated prog_counter on the counter side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_counter_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int REP_W = 8;
    localparam int N_CYC = 4000;

    logic             clk = 1'b0;
    logic             rst_n;
`ifdef CNT_PAUSE_EN
    logic             pause;
`endif
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_up;
    logic [REP_W-1:0] cfg_repeat;
    logic             busy, tick, done, err;
    logic             cnt_load, cnt_enable, cnt_up_down;
    logic [WIDTH-1:0] cnt_load_value, cnt_max_count;
    logic [WIDTH-1:0] cnt_count;
    logic             cnt_tc, cnt_zero;

    int total = 0;
    int bad   = 0;

    prog_counter_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef CNT_PAUSE_EN
        .pause          (pause),
`endif
        .start          (start),
        .stop           (stop),
        .cfg_period     (cfg_period),
        .cfg_up         (cfg_up),
        .cfg_repeat     (cfg_repeat),
        .busy           (busy),
        .tick           (tick),
        .done           (done),
        .err            (err),
        .cnt_load       (cnt_load),
        .cnt_enable     (cnt_enable),
        .cnt_up_down    (cnt_up_down),
        .cnt_load_value (cnt_load_value),
        .cnt_max_count  (cnt_max_count),
        .cnt_count      (cnt_count),
        .cnt_tc         (cnt_tc),
        .cnt_zero       (cnt_zero)
    );

    always #5 clk = ~clk;

    // Emulated prog_counter: load wins, then count with wrap at the limits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_count <= '0;
        else if (cnt_load)   cnt_count <= cnt_load_value;
        else if (cnt_enable) begin
            if (cnt_up_down) cnt_count <= (cnt_count == cnt_max_count) ? '0 : cnt_count + 1'b1;
            else             cnt_count <= (cnt_count == '0) ? cnt_max_count : cnt_count - 1'b1;
        end
    end
    assign cnt_tc   = (cnt_count == cnt_max_count);
    assign cnt_zero = (cnt_count == '0);

    // Reference model: an interval is one load cycle (k=0) followed by
    // p+1 counting cycles (k=1..p+1); it completes after the k=p+1 cycle.
    bit         m_active, m_paused, m_up;
    int         m_k, m_p, m_rem;
    bit         m_tick, m_done, m_err;
    int         n_ticks = 0, n_dones = 0, n_errs = 0;

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_up = 0;
        m_k = 0; m_p = 0; m_rem = 0;
        m_tick = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit pz;
        pz = 0;
`ifdef CNT_PAUSE_EN
        pz = pause;
`endif
        m_tick = 0; m_done = 0; m_err = 0;
        if (stop) begin
            m_active = 0;
            m_paused = 0;
        end else if (!m_active) begin
            if (start) begin
                if (cfg_period == 0) m_err = 1;
                else begin
                    m_active = 1; m_paused = 0; m_k = 0;
                    m_p = int'(cfg_period); m_up = cfg_up; m_rem = int'(cfg_repeat);
                end
            end
        end else if (m_paused) begin
            if (!pz) m_paused = 0;
        end else if (m_k == 0) begin
            m_k = 1;
        end else if (m_k == m_p + 1) begin
            m_tick = 1;
            if (m_rem == 1) begin
                m_done = 1; m_active = 0; m_rem = 0;
            end else begin
                if (m_rem != 0) m_rem = m_rem - 1;
                m_k = 0;
            end
        end else begin
            m_k = m_k + 1;
            if (pz) m_paused = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_lv;
        e_lv = m_up ? 32'd0 : 32'(m_p);
        chk({tag, "_busy"},  32'(busy),  32'(m_active));
        chk({tag, "_tick"},  32'(tick),  32'(m_tick));
        chk({tag, "_done"},  32'(done),  32'(m_done));
        chk({tag, "_err"},   32'(err),   32'(m_err));
        chk({tag, "_load"},  32'(cnt_load),   32'(m_active && m_k == 0));
        chk({tag, "_en"},    32'(cnt_enable), 32'(m_active && m_k >= 1 && !m_paused));
        chk({tag, "_updn"},  32'(cnt_up_down), 32'(m_up));
        chk({tag, "_max"},   32'(cnt_max_count), 32'(m_p));
        chk({tag, "_ldval"}, 32'(cnt_load_value), e_lv);
        // While counting up, the live count tracks the interval position.
        if (m_active && m_up && m_k >= 1)
            chk({tag, "_cnt"}, 32'(cnt_count), 32'(m_k - 1));
    endtask

    task automatic drive_random();
        start      = ($urandom_range(0, 3) == 0);
        stop       = ($urandom_range(0, 59) == 0);
        cfg_period = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 6));
        cfg_up     = 1'($urandom_range(0, 1));
        cfg_repeat = REP_W'($urandom_range(0, 3));
`ifdef CNT_PAUSE_EN
        if ($urandom_range(0, 5) == 0) pause = ~pause;
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_period = '0; cfg_up = 1'b0; cfg_repeat = '0;
`ifdef CNT_PAUSE_EN
        pause = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("rst");
        #2 rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == N_CYC / 2) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("midrst");
                #1 rst_n = 1'b1;
            end
            drive_random();
            @(posedge clk);
            model_step();
            if (m_tick) n_ticks++;
            if (m_done) n_dones++;
            if (m_err)  n_errs++;
            @(negedge clk);
            check_outputs("run");
        end

        // Guard against a run whose stimulus never exercised completion paths.
        chk("cov_tick", 32'(n_ticks > 20), 32'd1);
        chk("cov_done", 32'(n_dones > 5),  32'd1);
        chk("cov_err",  32'(n_errs > 5),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
